// File: rtl/fp_link_pkg.sv
// Shared definitions for the CPU-side AWP link: controller states, LP register codes
// and default job limits.
package fp_link_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_MEM,
        S_REG,
        S_ACK,
        S_DONE,
        S_FAULT
    } linkState_e;

    localparam logic [1:0]  R1 = 2'd1;
    localparam logic [1:0]  R2 = 2'd2;
    localparam logic [1:0]  R3 = 2'd3;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1023;
    localparam logic [2:0]  WORDS_DEFAULT   = 3'd4;

    // LP value 0 has no register behind it; only r1..r3 are reachable.
    function automatic logic lpSelectsReg(input logic [1:0] lp);
        return (lp == R1) || (lp == R2) || (lp == R3);
    endfunction

endpackage

// File: rtl/fp_link_timer.sv
// Load / count-down / expire counter guarding how long a memory read may stay unanswered.
module fp_link_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadVal_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A loaded value N expires on the (N+1)-th enabled cycle.
    assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/fp_cpu_link.sv
// CPU-side responder for the AWP: launches a job, serves memory and r1..r3 register
// requests with a 4-phase oken handshake, and reports completion or faults.
module fp_cpu_link
    import fp_link_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [2:0]  WORDS   = WORDS_DEFAULT
) (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        fp_go_i,
    input  logic [15:0] ar_i,
    output logic        efp_o,
    input  logic        sr_fp_i,
    input  logic        read_fp_i,
    input  logic        rlp_fp_i,
    input  logic        s_fp_i,
    input  logic        lpa_i,
    input  logic        lpb_i,
    input  logic        ekc_fp_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ok_i,
    input  logic        mem_nok_i,
    input  logic [15:0] mem_rdata_i,
    input  logic [15:0] reg_rdata_i,
    output logic [1:0]  reg_sel_o,
    output logic        reg_re_o,
    output logic        reg_we_o,
    output logic [15:0] fp_data_o,
    output logic        oken_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        alarm_o
);

    linkState_e  state_q, state_d;
    logic [15:0] baseAddr_q, baseAddr_d;
    logic [2:0]  wordCnt_q, wordCnt_d;
    logic [15:0] fpData_q, fpData_d;
    logic        alarm_q, alarm_d;
    logic        ekcPend_q, ekcPend_d;
    logic        regPhase_q, regPhase_d;
    logic        regStore_q, regStore_d;

    logic        timerLoad;
    logic        timerEn;
    logic        timerExpired;
    logic [1:0]  lp;

    assign lp = {lpb_i, lpa_i};

    fp_link_timer #(
        .WIDTH(16)
    ) u_timer (
        .clk_i     (clk_i),
        .clr_i     (clr_i),
        .load_i    (timerLoad),
        .loadVal_i (TIMEOUT),
        .en_i      (timerEn),
        .expired_o (timerExpired)
    );

    always_comb begin
        state_d    = state_q;
        baseAddr_d = baseAddr_q;
        wordCnt_d  = wordCnt_q;
        fpData_d   = fpData_q;
        alarm_d    = alarm_q;
        ekcPend_d  = ekcPend_q;
        regPhase_d = regPhase_q;
        regStore_d = regStore_q;
        timerLoad  = 1'b0;
        timerEn    = 1'b0;
        efp_o      = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = 16'd0;
        reg_sel_o  = 2'd0;
        reg_re_o   = 1'b0;
        reg_we_o   = 1'b0;
        oken_o     = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (fp_go_i) begin
                    state_d    = S_START;
                    baseAddr_d = ar_i;
                    wordCnt_d  = 3'd0;
                    alarm_d    = 1'b0;
                    ekcPend_d  = 1'b0;
                end
            end
            S_START: begin
                efp_o   = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (ekc_fp_i || ekcPend_q) begin
                    state_d   = S_DONE;
                    ekcPend_d = 1'b0;
                end else if (sr_fp_i) begin
                    if (read_fp_i && !rlp_fp_i) begin
                        if (wordCnt_q >= WORDS) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d   = S_MEM;
                            timerLoad = 1'b1;
                        end
                    end else if (rlp_fp_i && !read_fp_i) begin
                        state_d    = S_REG;
                        regPhase_d = 1'b0;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                timerEn    = 1'b1;
                mem_addr_o = baseAddr_q + {13'd0, wordCnt_q};
                if (mem_ok_i) begin
                    fpData_d  = mem_rdata_i;
                    wordCnt_d = wordCnt_q + 3'd1;
                    state_d   = S_ACK;
                end else if (mem_nok_i || timerExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_REG: begin
                reg_sel_o = lp;
                // Phase 0 strobes the register file, phase 1 waits for its registered read data.
                if (!regPhase_q) begin
                    if (!lpSelectsReg(lp)) begin
                        state_d = S_FAULT;
                    end else begin
                        reg_we_o   = s_fp_i;
                        reg_re_o   = !s_fp_i;
                        regStore_d = s_fp_i;
                        regPhase_d = 1'b1;
                    end
                end else begin
                    if (!regStore_q) begin
                        fpData_d = reg_rdata_i;
                    end
                    regPhase_d = 1'b0;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                oken_o = 1'b1;
                if (ekc_fp_i) begin
                    ekcPend_d = 1'b1;
                end
                if (!sr_fp_i) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (ekc_fp_i || ekcPend_q) begin
                    ekcPend_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_FAULT) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= S_IDLE;
            baseAddr_q <= 16'd0;
            wordCnt_q  <= 3'd0;
            fpData_q   <= 16'd0;
            alarm_q    <= 1'b0;
            ekcPend_q  <= 1'b0;
            regPhase_q <= 1'b0;
            regStore_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baseAddr_q <= baseAddr_d;
            wordCnt_q  <= wordCnt_d;
            fpData_q   <= fpData_d;
            alarm_q    <= alarm_d;
            ekcPend_q  <= ekcPend_d;
            regPhase_q <= regPhase_d;
            regStore_q <= regStore_d;
        end
    end

    assign fp_data_o = fpData_q;
    assign alarm_o   = alarm_q;

endmodule
